// File: rtl/mux_2to1.sv
// Two-input mux: combinational y, enable-gated registered y_q,
// and a saturating counter of sel transitions for debug.
module mux_2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] sel_cnt
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_sel_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;
  logic             w_sat;

  assign w_y      = sel ? i1 : i0;
  assign w_toggle = sel ^ r_sel_d;
  assign w_sat    = &r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else if (en) begin
      r_y_q <= w_y;
    end
  end

  // Counter sticks at all-ones once saturated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sel_d <= sel;
      if (w_toggle && !w_sat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign y       = w_y;
  assign y_q     = r_y_q;
  assign sel_cnt = r_cnt;

endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: WIDTH=1 and WIDTH=8 instances share control,
// checked against a reference model of the mux and toggle counter.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       en;
  logic       a0, a1;
  logic       ay, ayq;
  logic [7:0] acnt;
  logic [7:0] b0, b1;
  logic [7:0] by, byq;
  logic [7:0] bcnt;

  int checks   = 0;
  int failures = 0;

  int m_yq1;
  int m_yq8;
  int m_cnt;
  int m_prev;

  mux_2to1 #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n), .i0(a0), .i1(a1),
    .sel(sel), .en(en), .y(ay), .y_q(ayq), .sel_cnt(acnt)
  );

  mux_2to1 #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .i0(b0), .i1(b1),
    .sel(sel), .en(en), .y(by), .y_q(byq), .sel_cnt(bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the registered state
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_yq1  = 0;
      m_yq8  = 0;
      m_cnt  = 0;
      m_prev = 0;
    end else begin
      if (en) begin
        m_yq1 = sel ? int'(a1) : int'(a0);
        m_yq8 = sel ? int'(b1) : int'(b0);
      end
      if (int'(sel) != m_prev) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      m_prev = int'(sel);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_yq1"}, {31'd0, ayq}, m_yq1);
    chk({tag, "_yq8"}, {24'd0, byq}, m_yq8);
    chk({tag, "_cnt1"}, {24'd0, acnt}, m_cnt);
    chk({tag, "_cnt8"}, {24'd0, bcnt}, m_cnt);
  endtask

  task automatic chk_y(input string tag);
    chk({tag, "_y1"}, {31'd0, ay}, sel ? int'(a1) : int'(a0));
    chk({tag, "_y8"}, {24'd0, by}, sel ? int'(b1) : int'(b0));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; sel = 1'b0;
    a0 = 1'b1; a1 = 1'b0; b0 = 8'h5A; b1 = 8'hC3;
    #2;
    chk("rst_y", {31'd0, ay}, 32'd1);
    tick();
    tick();
    chk("rst_yq", {31'd0, ayq}, 32'd0);
    chk("rst_cnt", {24'd0, acnt}, 32'd0);
    chk("rst_y_during", {31'd0, ay}, 32'd1);
    chk_regs("rst");

    rst_n = 1'b1; en = 1'b1; a1 = 1'b1; sel = 1'b1;
    tick();
    chk("load_yq", {31'd0, ayq}, 32'd1);
    chk_regs("load");
    en = 1'b0; a1 = 1'b0;
    #2;
    chk("hold_y", {31'd0, ay}, 32'd0);
    tick();
    chk("hold_yq", {31'd0, ayq}, 32'd1);
    chk_regs("hold");

    for (int k = 0; k < 8; k++) begin
      a0  = k[2];
      a1  = k[1];
      sel = k[0];
      #2;
      chk($sformatf("combo%0d", k), {31'd0, ay},
          k[0] ? {31'd0, k[1]} : {31'd0, k[2]});
    end

    for (int k = 0; k < 10; k++) begin
      a0  = 1'($urandom);
      a1  = 1'($urandom);
      b0  = 8'($urandom);
      b1  = 8'($urandom);
      sel = 1'($urandom);
      #2;
      chk_y($sformatf("rnd%0d", k));
    end

    // Mid-operation reset with en=1: reset must win
    tick();
    chk_regs("pre_midrst");
    rst_n = 1'b0; en = 1'b1; a0 = 1'b1; a1 = 1'b1; sel = 1'b1;
    b0 = 8'hFF; b1 = 8'hFF;
    tick();
    chk("midrst_yq", {31'd0, ayq}, 32'd0);
    chk_regs("midrst");
    chk_y("midrst");
    rst_n = 1'b1;

    en = 1'b1;
    for (int k = 0; k < 300; k++) begin
      sel = ~sel;
      a0  = 1'($urandom);
      a1  = 1'($urandom);
      b0  = 8'($urandom);
      b1  = 8'($urandom);
      tick();
      if (k % 50 == 0 || k == 254 || k == 255) chk_regs($sformatf("tog%0d", k));
    end
    chk("sat_cnt", {24'd0, acnt}, 32'd255);
    for (int k = 0; k < 4; k++) begin
      sel = ~sel;
      tick();
    end
    chk("sat_stay", {24'd0, bcnt}, 32'd255);
    chk_regs("sat");

    b0 = 8'hA5; b1 = 8'h3C; sel = 1'b0;
    #2;
    chk("w8_sel0", {24'd0, by}, 32'hA5);
    sel = 1'b1;
    #2;
    chk("w8_sel1", {24'd0, by}, 32'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
